// File: rtl/mem_if_pkg.sv
// Shared definitions for the core's data-memory initiator (and the fetch side):
// state encoding, word geometry and byte-address to word-index decode.
package mem_if_pkg;

   localparam int unsigned WORD_BYTES          = 4;
   localparam int unsigned MAU_TIMEOUT_DEFAULT = 16;
   localparam int unsigned ADDR_MAX_W          = 64;
   localparam int unsigned INDEX_MAX_W         = ADDR_MAX_W - 2;

   typedef enum logic [2:0] {
      IDLE,
      WR_ISSUE,
      WR_WAIT,
      RD_ISSUE,
      RD_WAIT,
      RESP
   } mau_state_t;

   typedef struct packed {
      logic                   err;
      logic [INDEX_MAX_W-1:0] index;
   } addr_chk_t;

   // Word index of a byte address, flagging misalignment or any bit above the memory depth.
   function automatic addr_chk_t addr_to_index(input logic [ADDR_MAX_W-1:0] addr,
                                               input int unsigned           index_w);
      addr_chk_t chk;
      chk.index = INDEX_MAX_W'(addr >> $clog2(WORD_BYTES)) &
                  ((INDEX_MAX_W'(1) << index_w) - INDEX_MAX_W'(1));
      chk.err   = (addr[1:0] != 2'b00) || ((addr >> (index_w + 2)) != '0);
      return chk;
   endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Data-memory initiator: issues one load/store at a time, waits for the memory
// strobe (bounded by a timeout) and returns data/completion to the pipeline.
module mem_access_unit
   import mem_if_pkg::*;
#(
   parameter int unsigned DATA_MEM_WIDTH = 3,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = MAU_TIMEOUT_DEFAULT
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      req_valid,
   input  logic                      req_write,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [31:0]               req_wdata,
   output logic                      req_ready,
   output logic                      resp_valid,
   output logic [31:0]               resp_data,
   output logic                      resp_err,
   output logic                      stall,
   output logic                      mem_write_enable,
   output logic [DATA_MEM_WIDTH-1:0] mem_write_index,
   output logic [31:0]               mem_write_data,
   input  logic                      mem_write_ready,
   output logic                      mem_read_enable,
   output logic [DATA_MEM_WIDTH-1:0] mem_read_index,
   input  logic [31:0]               mem_read_data,
   input  logic                      mem_read_valid
);

   localparam int unsigned CNT_W       = 8;
   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

   mau_state_t                state_q, state_d;
   logic [DATA_MEM_WIDTH-1:0] idx_q, idx_d;
   logic [31:0]               wdata_q, wdata_d;
   logic [31:0]               rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;

   addr_chk_t        chk_c;
   logic [CNT_W-1:0] cnt_inc_c;
   logic             timeout_c;
   logic             unused_idx_c;

   assign chk_c        = addr_to_index(ADDR_MAX_W'(req_addr), DATA_MEM_WIDTH);
   assign unused_idx_c = ^chk_c.index;
   assign cnt_inc_c    = cnt_q + CNT_W'(1);
   assign timeout_c    = (cnt_inc_c >= TIMEOUT_LIM);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state; a strobe seen in the issue cycle completes immediately, and beats the timeout.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               cnt_d = '0;
               if (chk_c.err) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  idx_d   = DATA_MEM_WIDTH'(chk_c.index);
                  wdata_d = req_wdata;
                  state_d = req_write ? WR_ISSUE : RD_ISSUE;
               end
            end
         end
         WR_ISSUE: begin
            if (mem_write_ready) begin
               err_d   = 1'b0;
               state_d = RESP;
            end else begin
               state_d = WR_WAIT;
            end
         end
         WR_WAIT: begin
            cnt_d = cnt_inc_c;
            if (mem_write_ready) begin
               err_d   = 1'b0;
               state_d = RESP;
            end else if (timeout_c) begin
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RD_ISSUE: begin
            if (mem_read_valid) begin
               rdata_d = mem_read_data;
               err_d   = 1'b0;
               state_d = RESP;
            end else begin
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            cnt_d = cnt_inc_c;
            if (mem_read_valid) begin
               rdata_d = mem_read_data;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (timeout_c) begin
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready        = (state_q == IDLE);
   assign resp_valid       = (state_q == RESP);
   assign resp_data        = rdata_q;
   assign resp_err         = err_q;
   assign stall            = req_valid && !(state_q == IDLE && chk_c.err) && (state_q != RESP);
   assign mem_write_enable = (state_q == WR_ISSUE);
   assign mem_write_index  = idx_q;
   assign mem_write_data   = wdata_q;
   assign mem_read_enable  = (state_q == RD_ISSUE);
   assign mem_read_index   = idx_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random transactions checked
// against a transaction-level model (address rules, latency formula, memory array).
module tb_mem_access_unit;

   localparam int unsigned DMW   = 3;
   localparam int unsigned AW    = 32;
   localparam int unsigned TO    = 4;
   localparam int unsigned DEPTH = 1 << DMW;
   localparam int          NEVER = -1;

   logic           CLK = 1'b0;
   logic           RST;
   logic           req_valid, req_write;
   logic [AW-1:0]  req_addr;
   logic [31:0]    req_wdata;
   logic           req_ready, resp_valid, resp_err, stall;
   logic [31:0]    resp_data;
   logic           mem_write_enable, mem_write_ready;
   logic [DMW-1:0] mem_write_index, mem_read_index;
   logic [31:0]    mem_write_data, mem_read_data;
   logic           mem_read_enable, mem_read_valid;

   int errors = 0;
   int checks = 0;

   logic [31:0] ref_mem [DEPTH];
   logic [31:0] tb_mem  [DEPTH];
   logic [31:0] ref_rdata;

   mem_access_unit #(
      .DATA_MEM_WIDTH(DMW),
      .ADDR_WIDTH    (AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK             (CLK),
      .RST             (RST),
      .req_valid       (req_valid),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_ready       (req_ready),
      .resp_valid      (resp_valid),
      .resp_data       (resp_data),
      .resp_err        (resp_err),
      .stall           (stall),
      .mem_write_enable(mem_write_enable),
      .mem_write_index (mem_write_index),
      .mem_write_data  (mem_write_data),
      .mem_write_ready (mem_write_ready),
      .mem_read_enable (mem_read_enable),
      .mem_read_index  (mem_read_index),
      .mem_read_data   (mem_read_data),
      .mem_read_valid  (mem_read_valid)
   );

   always #5 CLK = ~CLK;

   // One transaction; d = cycles after issue at which memory strobes (0 = issue cycle), NEVER = no strobe.
   task automatic do_txn(input string tag, input bit w, input logic [31:0] addr,
                         input logic [31:0] wd, input int d, output logic [31:0] got_data);
      bit          bad, exp_err, strobe, stall_bad, both, ready0, got_err;
      int          exp_lat, resp_cyc, wen_n, ren_n, en_cyc, idx;
      logic [31:0] exp_data, en_data;
      logic [DMW-1:0] en_idx;
      bad = (addr % 4 != 0) || (addr >= 4 * DEPTH);
      idx = int'(addr / 4);
      if (bad) begin
         exp_lat = 1; exp_err = 1'b1;
      end else if (d < 0 || d > int'(TO)) begin
         exp_lat = 2 + int'(TO); exp_err = 1'b1;
      end else begin
         exp_lat = 2 + d; exp_err = 1'b0;
      end
      exp_data = (!bad && !exp_err && !w) ? ref_mem[idx] : ref_rdata;

      resp_cyc = -1; wen_n = 0; ren_n = 0; en_cyc = -1; en_idx = '0; en_data = '0;
      stall_bad = 0; both = 0; ready0 = 0; got_err = 0; got_data = '0;
      @(posedge CLK); #1;
      req_valid = 1'b1; req_write = w; req_addr = addr; req_wdata = wd;
      for (int cyc = 0; cyc < 64 && resp_cyc < 0; cyc++) begin
         strobe          = (d >= 0) && (cyc == 1 + d);
         mem_write_ready = strobe && w;
         mem_read_valid  = strobe && !w;
         mem_read_data   = mem_read_valid ? tb_mem[mem_read_index] : $urandom();
         if (mem_write_ready) tb_mem[mem_write_index] = mem_write_data;
         @(negedge CLK);
         if (cyc == 0) ready0 = req_ready;
         if (stall !== (!bad && cyc < exp_lat)) stall_bad = 1;
         if (mem_write_enable && mem_read_enable) both = 1;
         if (mem_write_enable) begin
            wen_n++; en_cyc = cyc; en_idx = mem_write_index; en_data = mem_write_data;
         end
         if (mem_read_enable) begin
            ren_n++; en_cyc = cyc; en_idx = mem_read_index;
         end
         if (resp_valid) begin
            resp_cyc = cyc; got_err = resp_err; got_data = resp_data; req_valid = 1'b0;
         end
         if (resp_cyc < 0) begin
            @(posedge CLK); #1;
         end
      end
      mem_write_ready = 1'b0; mem_read_valid = 1'b0; req_valid = 1'b0;

      checks++;
      if (resp_cyc < 0) begin
         errors++;
         $display("FAIL %s no_resp: no resp_valid within 64 cycles", tag);
         return;
      end
      checks++;
      if (resp_cyc !== exp_lat) begin
         errors++; $display("FAIL %s latency: got %0d expected %0d", tag, resp_cyc, exp_lat);
      end
      checks++;
      if (got_err !== exp_err) begin
         errors++; $display("FAIL %s resp_err: got %0b expected %0b", tag, got_err, exp_err);
      end
      checks++;
      if (got_data !== exp_data) begin
         errors++; $display("FAIL %s resp_data: got %h expected %h", tag, got_data, exp_data);
      end
      checks++;
      if (ready0 !== 1'b1) begin
         errors++; $display("FAIL %s req_ready: got %0b expected 1", tag, ready0);
      end
      checks++;
      if (stall_bad || both) begin
         errors++; $display("FAIL %s stall_or_overlap: stall_bad %0b both_en %0b expected 0 0", tag, stall_bad, both);
      end
      checks++;
      if (wen_n !== ((!bad && w) ? 1 : 0) || ren_n !== ((!bad && !w) ? 1 : 0)) begin
         errors++;
         $display("FAIL %s enables: got wr %0d rd %0d expected wr %0d rd %0d", tag, wen_n, ren_n,
                  (!bad && w) ? 1 : 0, (!bad && !w) ? 1 : 0);
      end
      if (!bad) begin
         checks++;
         if (en_cyc !== 1 || en_idx !== DMW'(idx) || (w && en_data !== wd)) begin
            errors++;
            $display("FAIL %s issue: got cyc %0d idx %0d data %h expected cyc 1 idx %0d data %h",
                     tag, en_cyc, en_idx, en_data, idx, wd);
         end
      end
      if (!bad && !exp_err) begin
         if (w) ref_mem[idx] = wd;
         else   ref_rdata    = ref_mem[idx];
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", req_ready); end
      checks++;
      if ({resp_valid, resp_err, stall, mem_write_enable, mem_read_enable} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {resp_valid, resp_err, stall, mem_write_enable, mem_read_enable});
      end
      checks++;
      if (resp_data !== 32'h0 || mem_write_data !== 32'h0) begin
         errors++; $display("FAIL reset_data: got %h %h expected 0 0", resp_data, mem_write_data);
      end
      checks++;
      if (mem_write_index !== '0 || mem_read_index !== '0) begin
         errors++; $display("FAIL reset_index: got %0d %0d expected 0 0", mem_write_index, mem_read_index);
      end
      RST = 1'b0;
      ref_rdata = '0;
   endtask

   task automatic test_store_load();
      logic [31:0] r;
      do_txn("store_c", 1'b1, 32'h0000000C, 32'hDEADBEEF, 1, r);
      do_txn("load_c", 1'b0, 32'h0000000C, 32'h0, 1, r);
      checks++;
      if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL load_c_value: got %h expected deadbeef", r); end
   endtask

   task automatic test_errors();
      logic [31:0] r;
      do_txn("misaligned", 1'b0, 32'h00000006, 32'h0, 1, r);
      do_txn("out_of_range", 1'b1, 32'h00000020, 32'h12345678, 1, r);
      do_txn("far_range", 1'b0, 32'h80000000, 32'h0, 1, r);
   endtask

   task automatic test_timeout();
      logic [31:0] r;
      do_txn("rd_timeout", 1'b0, 32'h00000004, 32'h0, NEVER, r);
      do_txn("wr_timeout", 1'b1, 32'h00000008, 32'hCAFEF00D, NEVER, r);
      do_txn("after_timeout", 1'b0, 32'h00000004, 32'h0, 2, r);
      do_txn("race_store", 1'b1, 32'h00000010, 32'hA5A55A5A, int'(TO), r);
      do_txn("race_load", 1'b0, 32'h00000010, 32'h0, int'(TO), r);
      checks++;
      if (r !== 32'hA5A55A5A) begin errors++; $display("FAIL race_value: got %h expected a5a55a5a", r); end
   endtask

   task automatic test_issue_strobe();
      logic [31:0] r;
      do_txn("issue_store", 1'b1, 32'h0000001C, 32'h0BADF00D, 0, r);
      do_txn("issue_load", 1'b0, 32'h0000001C, 32'h0, 0, r);
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      bit bad;
      @(posedge CLK); #1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h00000008;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      checks++;
      if (stall !== 1'b1 || mem_read_enable !== 1'b0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_wait: got stall %0b ren %0b ready %0b expected 1 0 0", stall, mem_read_enable, req_ready);
      end
      RST = 1'b1; req_valid = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
      ref_rdata = '0;
      checks++;
      if (req_ready !== 1'b1 || stall !== 1'b0 || resp_valid !== 1'b0 || mem_read_enable !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got ready %0b stall %0b resp %0b ren %0b expected 1 0 0 0",
                  req_ready, stall, resp_valid, mem_read_enable);
      end
      mem_read_valid = 1'b1; mem_read_data = 32'hBAD0BAD0;
      @(posedge CLK); #1;
      mem_read_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_data !== 32'h0) bad = 1;
         @(posedge CLK); #1;
      end
      checks++;
      if (bad) begin errors++; $display("FAIL late_strobe: got a response or state change, expected none"); end
      do_txn("post_reset_ld", 1'b0, 32'h00000008, 32'h0, 1, r);
      do_txn("b2b_ld", 1'b0, 32'h0000000C, 32'h0, 1, r);
   endtask

   task automatic test_random();
      logic [31:0] r, a;
      int d, sel;
      for (int n = 0; n < 40; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 8)       a = 32'(sel * 4);
         else if (sel == 8) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
         else               a = 32'($urandom_range(DEPTH, 1000) * 4);
         d = int'($urandom_range(0, TO + 1));
         if (d == int'(TO) + 1) d = NEVER;
         do_txn("random", 1'($urandom_range(0, 1)), a, $urandom(), d, r);
      end
   endtask

   initial begin
      RST = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      mem_write_ready = 1'b0; mem_read_valid = 1'b0; mem_read_data = '0;
      ref_rdata = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         ref_mem[i] = $urandom();
         tb_mem[i]  = ref_mem[i];
      end
      test_reset();
      test_store_load();
      test_errors();
      test_timeout();
      test_issue_strobe();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
